// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller: decode handshake, mul/div launch/wait, writeback retire, redirect + timed flush.
// Optional macro EX_MD_TIMEOUT_EN adds an MD_WAIT timeout counter and a sticky md_timeout flag.
module ex_issue_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MD_TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    output logic        id_ready,
    output logic [31:0] ex_instr,
    output logic [31:0] ex_pc,
    input  logic        bt,
    input  logic [31:0] branch_addr,
    output logic        md_start,
    input  logic        md_done,
    output logic        ex_valid,
    input  logic        wb_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] retire_count
`ifdef EX_MD_TIMEOUT_EN
    ,
    output logic        md_timeout
`endif
);

    // state   | meaning
    // IDLE    | ready for an instruction from decode
    // EXEC    | result presented to writeback, waiting for wb_ready
    // MD_WAIT | mul/div launched, waiting for md_done
    // FLUSH   | redirect issued, holding flush for FLUSH_CYCLES
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXEC    = 2'd1;
    localparam logic [1:0] S_MD_WAIT = 2'd2;
    localparam logic [1:0] S_FLUSH   = 2'd3;

    logic [1:0] state;
    logic       md_first;
    logic [3:0] flush_cnt;
    logic       is_br;
    logic       is_jmp;
    logic       accept_md;
    logic       retire;
    logic       take;
    logic       md_done_ok;
    logic       md_exit;

    assign accept_md = (id_instr[6:0] == 7'b0110011) && (id_instr[31:25] == 7'b0000001);
    assign is_br     = (ex_instr[6:0] == 7'b1100011);
    assign is_jmp    = (ex_instr[6:0] == 7'b1101111) || (ex_instr[6:0] == 7'b1100111);

    assign id_ready       = !rst && (state == S_IDLE);
    assign ex_valid       = !rst && (state == S_EXEC);
    assign md_start       = !rst && (state == S_MD_WAIT) && md_first;
    assign flush          = !rst && (state == S_FLUSH);
    assign retire         = ex_valid && wb_ready;
    assign take           = retire && (is_jmp || (is_br && bt));
    assign redirect_valid = take;
    assign redirect_pc    = branch_addr;

    // The launch cycle never counts as completion, even if md_done is already high.
    assign md_done_ok = (state == S_MD_WAIT) && !md_first && md_done;

`ifdef EX_MD_TIMEOUT_EN
    logic [7:0] md_cnt;
    logic       md_tmo_hit;
    assign md_tmo_hit = (state == S_MD_WAIT) && (md_cnt == 8'(MD_TIMEOUT - 1));
    assign md_exit    = md_done_ok || md_tmo_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt     <= 8'd0;
            md_timeout <= 1'b0;
        end else if (state == S_IDLE) begin
            md_cnt <= 8'd0;
        end else if (state == S_MD_WAIT) begin
            md_cnt <= md_cnt + 8'd1;
            if (md_tmo_hit && !md_done_ok) md_timeout <= 1'b1;
        end
    end
`else
    assign md_exit = md_done_ok;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ex_instr     <= 32'd0;
            ex_pc        <= 32'd0;
            retire_count <= 32'd0;
            flush_cnt    <= 4'd0;
            md_first     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (id_valid) begin
                        ex_instr <= id_instr;
                        ex_pc    <= id_pc;
                        md_first <= accept_md;
                        state    <= accept_md ? S_MD_WAIT : S_EXEC;
                    end
                end
                S_MD_WAIT: begin
                    md_first <= 1'b0;
                    if (md_exit) state <= S_EXEC;
                end
                S_EXEC: begin
                    if (retire) begin
                        retire_count <= retire_count + 32'd1;
                        if (take) begin
                            flush_cnt <= 4'(FLUSH_CYCLES);
                            state     <= S_FLUSH;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    flush_cnt <= flush_cnt - 4'd1;
                    if (flush_cnt == 4'd1) state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Self-checking bench for ex_issue_ctrl: directed scenarios plus randomized transactions against a transaction-level model.
module tb_ex_issue_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int MD_TIMEOUT   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = 32'd0;
    logic [31:0] id_pc = 32'd0;
    logic        id_ready;
    logic [31:0] ex_instr;
    logic [31:0] ex_pc;
    logic        bt = 1'b0;
    logic [31:0] branch_addr = 32'd0;
    logic        md_start;
    logic        md_done = 1'b0;
    logic        ex_valid;
    logic        wb_ready = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] retire_count;
`ifdef EX_MD_TIMEOUT_EN
    logic        md_timeout;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_retire = 32'd0;

    always #5 clk = ~clk;

    ex_issue_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .MD_TIMEOUT(MD_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_ready(id_ready), .ex_instr(ex_instr), .ex_pc(ex_pc), .bt(bt),
        .branch_addr(branch_addr), .md_start(md_start), .md_done(md_done),
        .ex_valid(ex_valid), .wb_ready(wb_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .retire_count(retire_count)
`ifdef EX_MD_TIMEOUT_EN
        , .md_timeout(md_timeout)
`endif
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // One instruction from accept to the first IDLE cycle after retire (and flush, if any).
    task automatic do_txn(input logic [31:0] instr, input logic [31:0] pc, input int wb_delay,
                          input logic bt_val, input logic [31:0] target, input int md_delay,
                          input logic md_early);
        logic [6:0] op;
        logic       is_md;
        logic       exp_redir;
        op        = instr[6:0];
        is_md     = (op == 7'h33) && (instr[31:25] == 7'b0000001);
        exp_redir = (op == 7'h6F) || (op == 7'h67) || ((op == 7'h63) && bt_val);

        id_valid = 1'b1; id_instr = instr; id_pc = pc;
        md_done = 1'($urandom); wb_ready = 1'($urandom); #1;
        n_checks++;
        if (id_ready !== 1'b1) begin n_fail++; $display("FAIL accept_ready: got %b want 1", id_ready); end

        @(negedge clk);
        id_valid = 1'($urandom); id_instr = $urandom; md_done = is_md ? md_early : 1'($urandom);
        if (is_md) begin
            #1;
            n_checks++;
            if ({md_start, ex_valid, id_ready} !== 3'b100) begin
                n_fail++; $display("FAIL md_launch: md_start/ex_valid/id_ready got %b want 100", {md_start, ex_valid, id_ready});
            end
            for (int k = 1; k <= md_delay; k++) begin
                @(negedge clk);
                md_done = (k == md_delay); wb_ready = 1'($urandom); id_valid = 1'($urandom); #1;
                n_checks++;
                if ({md_start, ex_valid, id_ready} !== 3'b000) begin
                    n_fail++; $display("FAIL md_wait k=%0d: md_start/ex_valid/id_ready got %b want 000", k, {md_start, ex_valid, id_ready});
                end
            end
            @(negedge clk);
            md_done = 1'($urandom);
        end

        for (int k = 0; k <= wb_delay; k++) begin
            if (k > 0) begin
                @(negedge clk);
                md_done = 1'($urandom); id_valid = 1'($urandom); id_instr = $urandom;
            end
            wb_ready    = (k == wb_delay);
            bt          = (k == wb_delay) ? bt_val : 1'($urandom);
            branch_addr = (k == wb_delay) ? target : $urandom;
            #1;
            n_checks++;
            if ({ex_valid, id_ready, flush} !== 3'b100) begin
                n_fail++; $display("FAIL exec_state k=%0d: ex_valid/id_ready/flush got %b want 100", k, {ex_valid, id_ready, flush});
            end
            n_checks++;
            if (ex_instr !== instr || ex_pc !== pc) begin
                n_fail++; $display("FAIL exec_hold: instr/pc got %h/%h want %h/%h", ex_instr, ex_pc, instr, pc);
            end
            n_checks++;
            if (redirect_valid !== ((k == wb_delay) && exp_redir)) begin
                n_fail++; $display("FAIL redirect k=%0d: got %b want %b", k, redirect_valid, (k == wb_delay) && exp_redir);
            end
            if ((k == wb_delay) && exp_redir) begin
                n_checks++;
                if (redirect_pc !== target) begin
                    n_fail++; $display("FAIL redirect_pc: got %h want %h", redirect_pc, target);
                end
            end
        end
        exp_retire = exp_retire + 32'd1;

        if (exp_redir) begin
            for (int f = 0; f < FLUSH_CYCLES; f++) begin
                @(negedge clk);
                wb_ready = 1'($urandom); bt = 1'($urandom); md_done = 1'($urandom); id_valid = 1'($urandom); #1;
                n_checks++;
                if ({flush, id_ready, ex_valid, redirect_valid} !== 4'b1000) begin
                    n_fail++; $display("FAIL flush f=%0d: flush/id_ready/ex_valid/redirect got %b want 1000", f, {flush, id_ready, ex_valid, redirect_valid});
                end
            end
        end
        @(negedge clk);
        id_valid = 1'b0; wb_ready = 1'($urandom); md_done = 1'($urandom); #1;
        n_checks++;
        if ({flush, id_ready, ex_valid, md_start} !== 4'b0100) begin
            n_fail++; $display("FAIL back_to_idle: flush/id_ready/ex_valid/md_start got %b want 0100", {flush, id_ready, ex_valid, md_start});
        end
        n_checks++;
        if (retire_count !== exp_retire) begin
            n_fail++; $display("FAIL retire_count: got %0d want %0d", retire_count, exp_retire);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; id_valid = 1'b1; id_instr = 32'h002081B3; wb_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({id_ready, ex_valid, flush, md_start, redirect_valid} !== 5'b0 || retire_count !== 32'd0) begin
                n_fail++; $display("FAIL reset_hold c=%0d: outs %b cnt %0d want 00000 cnt 0", c, {id_ready, ex_valid, flush, md_start, redirect_valid}, retire_count);
            end
        end
        @(negedge clk);
        rst = 1'b0; id_valid = 1'b0; #1;
        n_checks++;
        if (id_ready !== 1'b1 || ex_instr !== 32'd0 || ex_pc !== 32'd0) begin
            n_fail++; $display("FAIL reset_release: id_ready %b instr %h pc %h want 1/0/0", id_ready, ex_instr, ex_pc);
        end
        exp_retire = 32'd0;
    endtask

    task automatic test_alu;
        do_txn(32'h002081B3, 32'h0000_0040, 0, 1'b1, 32'h1234, 1, 1'b0);
        do_txn(32'h002081B3, 32'h0000_0044, 0, 1'b0, 32'h0, 1, 1'b0);
    endtask

    task automatic test_backpressure;
        do_txn(32'h00310233, 32'h0000_0080, 4, 1'b0, 32'h0, 1, 1'b0);
    endtask

    task automatic test_branch;
        do_txn(32'h00208063, 32'h0000_0100, 0, 1'b1, 32'h0000_0140, 1, 1'b0);
        do_txn(32'h00208063, 32'h0000_0100, 0, 1'b0, 32'h0000_0140, 1, 1'b0);
        do_txn(32'h0100006F, 32'h0000_0200, 2, 1'b0, 32'h0000_0210, 1, 1'b0);
        do_txn(32'h00008067, 32'h0000_0300, 1, 1'b0, 32'h0000_0AB0, 1, 1'b0);
    endtask

    task automatic test_md;
        do_txn(32'h022081B3, 32'h0000_0400, 0, 1'b0, 32'h0, 5, 1'b1);
        do_txn(32'h0220C1B3, 32'h0000_0404, 2, 1'b1, 32'h0, 1, 1'b0);
    endtask

    task automatic test_reset_abort;
        id_valid = 1'b1; id_instr = 32'h022081B3; id_pc = 32'h500; md_done = 1'b0; #1;
        @(negedge clk);
        id_valid = 1'b0; #1;
        n_checks++;
        if (md_start !== 1'b1) begin n_fail++; $display("FAIL abort_launch: md_start got %b want 1", md_start); end
        rst = 1'b1; #1;
        n_checks++;
        if (md_start !== 1'b0 || id_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_forced: md_start/id_ready got %b%b want 00", md_start, id_ready);
        end
        @(negedge clk);
        rst = 1'b0; md_done = 1'b1; #1;
        @(negedge clk);
        md_done = 1'b0; #1;
        n_checks++;
        if ({id_ready, ex_valid, md_start} !== 3'b100 || retire_count !== 32'd0) begin
            n_fail++; $display("FAIL abort_idle: id_ready/ex_valid/md_start %b cnt %0d want 100 cnt 0", {id_ready, ex_valid, md_start}, retire_count);
        end
        exp_retire = 32'd0;
    endtask

    task automatic test_random;
        logic [31:0] instr;
        logic [6:0]  op;
        for (int t = 0; t < 40; t++) begin
            instr = $urandom;
            case ($urandom_range(0, 3))
                0: instr = {instr[31:7], 7'b1100011};
                1: instr = {instr[31:7], ($urandom_range(0, 1) == 0) ? 7'b1101111 : 7'b1100111};
                2: instr = {7'b0000001, instr[24:7], 7'b0110011};
                default: begin
                    op = instr[6:0];
                    if (op == 7'h63 || op == 7'h6F || op == 7'h67 || op == 7'h33) instr = {instr[31:7], 7'b0010011};
                end
            endcase
            do_txn(instr, $urandom, $urandom_range(0, 3), 1'($urandom), $urandom,
                   $urandom_range(1, MD_TIMEOUT - 1), 1'($urandom));
        end
    endtask

`ifdef EX_MD_TIMEOUT_EN
    task automatic test_timeout;
        do_txn(32'h022081B3, 32'h600, 0, 1'b0, 32'h0, MD_TIMEOUT - 1, 1'b0);
        n_checks++;
        if (md_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_priority: md_timeout got %b want 0", md_timeout); end

        id_valid = 1'b1; id_instr = 32'h022081B3; id_pc = 32'h700; md_done = 1'b0; #1;
        @(negedge clk);
        id_valid = 1'b0;
        for (int k = 0; k < MD_TIMEOUT; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_checks++;
            if (ex_valid !== 1'b0 || md_timeout !== 1'b0) begin
                n_fail++; $display("FAIL tmo_wait k=%0d: ex_valid/md_timeout got %b%b want 00", k, ex_valid, md_timeout);
            end
        end
        @(negedge clk);
        wb_ready = 1'b1; #1;
        n_checks++;
        if (ex_valid !== 1'b1 || md_timeout !== 1'b1) begin
            n_fail++; $display("FAIL tmo_fire: ex_valid/md_timeout got %b%b want 11", ex_valid, md_timeout);
        end
        exp_retire = exp_retire + 32'd1;
        @(negedge clk);
        wb_ready = 1'b0; #1;
        do_txn(32'h002081B3, 32'h704, 0, 1'b0, 32'h0, 1, 1'b0);
        n_checks++;
        if (md_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", md_timeout); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        n_checks++;
        if (md_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b want 0", md_timeout); end
        exp_retire = 32'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_backpressure();
        test_branch();
        test_md();
        test_reset_abort();
        test_random();
`ifdef EX_MD_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
